// File: rtl/dual_port_ram_pkg.sv
// Shared geometry defaults for the dual-port RAM.
package dual_port_ram_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  function automatic int mem_depth(input int aw);
    return 2 ** aw;
  endfunction
endpackage

// File: rtl/dual_port_ram_port.sv
// One RAM port: write-enable qualification and the registered read data.
module dual_port_ram_port
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              we_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // reset suppresses the write even though memory itself is never cleared
  assign we_o = sel_i & wr_i & ~rst;

  always_comb begin
    rdata_d = rdata_q;
    if (sel_i && !wr_i) rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, read-first across ports, port A wins write collisions.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr_rd_a,
  input  logic              wr_rd_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NUM_PORTS = 2;
  localparam int DEPTH_L   = mem_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH_L];

  logic [NUM_PORTS-1:0]             wr_rd, we;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, mem_rd, rdata;
  logic                             collide;

  assign wr_rd = {wr_rd_b, wr_rd_a};
  assign addr  = {addr_b, addr_a};
  assign wdata = {wdata_b, wdata_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign mem_rd[p] = mem_q[addr[p]];
    dual_port_ram_port #(.DATA_W(DATA_W)) u_port (
      .clk        (clk),
      .rst        (rst),
      .sel_i      (~cs),
      .wr_i       (wr_rd[p]),
      .mem_rdata_i(mem_rd[p]),
      .we_o       (we[p]),
      .rdata_o    (rdata[p])
    );
  end

  assign collide = we[0] & we[1] & (addr[0] == addr[1]);

  // reads above sample mem_q before these updates land, giving read-first
  always_ff @(posedge clk) begin
    if (we[0])            mem_q[addr[0]] <= wdata[0];
    if (we[1] && !collide) mem_q[addr[1]] <= wdata[1];
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed and randomized check of dual_port_ram against an array-based reference model.
module tb_dual_port_ram;
  logic       clk = 1'b0;
  logic       rst, cs, wr_rd_a, wr_rd_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] em [16];
  bit         kn [16];
  logic [7:0] ea, eb;
  bit         ka = 1'b0, kb = 1'b0;

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .wr_rd_a(wr_rd_a), .wr_rd_b(wr_rd_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  task automatic step(input bit r, input bit c, input bit wa, input bit wb,
                      input logic [3:0] aa, input logic [3:0] ab,
                      input logic [7:0] da, input logic [7:0] db, input string tag);
    @(negedge clk);
    rst = r; cs = c; wr_rd_a = wa; wr_rd_b = wb;
    addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
    @(posedge clk);
    if (r) begin
      ea = 8'h00; eb = 8'h00; ka = 1'b1; kb = 1'b1;
    end else if (!c) begin
      if (!wa) begin ea = em[aa]; ka = kn[aa]; end
      if (!wb) begin eb = em[ab]; kb = kn[ab]; end
      // B first so that A overwrites on a same-address collision
      if (wb) begin em[ab] = db; kn[ab] = 1'b1; end
      if (wa) begin em[aa] = da; kn[aa] = 1'b1; end
    end
    #1;
    if (ka) begin
      n_cmp++;
      assert (rdata_a === ea) else begin
        n_err++;
        $error("FAIL %s rdata_a observed=%h expected=%h", tag, rdata_a, ea);
      end
    end
    if (kb) begin
      n_cmp++;
      assert (rdata_b === eb) else begin
        n_err++;
        $error("FAIL %s rdata_b observed=%h expected=%h", tag, rdata_b, eb);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; wr_rd_a = 1'b0; wr_rd_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    for (int i = 0; i < 16; i++) kn[i] = 1'b0;

    step(1, 1, 0, 0, 0, 0, 0, 0, "reset");

    // known background so the deselect phase can prove memory was untouched
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 4'(i), 0, 8'(i ^ 8'h5A), 0, "prefill");
    step(1, 0, 0, 0, 0, 0, 0, 0, "reset2");

    for (int i = 0; i < 16; i++)
      step(0, 1, 1, 0, 4'(i), 0, 8'($urandom_range(0, 255)), 0, "desel_wr");
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 4'(i), 0, 0, "desel_rd");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 4'(i), 0, 0, "desel_verify");

    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 4'(i), 0, 8'(i * 3 + 1), 0, "a_wr");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 4'(i), 0, 0, "b_rd");

    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 4'(i), 0, 8'(8'hF0 ^ i), "b_wr");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 4'(i), 0, 0, 0, "a_rd");

    step(0, 0, 1, 1, 5, 5, 8'd77, 8'd98, "collide_wr");
    step(0, 0, 0, 0, 5, 5, 0, 0, "collide_rd");

    step(0, 0, 1, 0, 3, 0, 8'd10, 0, "rf_init");
    step(0, 0, 1, 0, 3, 3, 8'd55, 0, "rf_old");
    step(0, 0, 0, 0, 0, 3, 0, 0, "rf_new");

    step(0, 0, 0, 0, 5, 0, 0, 0, "pre_rst_rd");
    step(1, 0, 1, 0, 2, 0, 8'd99, 0, "rst_mid");
    step(0, 0, 0, 0, 2, 5, 0, 0, "post_rst_rd");

    for (int n = 0; n < 400; n++) begin
      logic [3:0] aa, ab;
      aa = 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, ab,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
